// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit unsigned subtractor (a - b), LSB first, one bit per
//   clock. A start in IDLE captures the operands. RUN then feeds one bit pair
//   plus the registered borrow through the full-subtract equations on each
//   clock. After WIDTH bits, diff/borrow_out update and done pulses for one
//   cycle.
//
//   Optional feature (macro SERIAL_SUBTRACTOR_BORROW_IN_EN):
//     adds input borrow_in, loaded into the borrow flop on the accepted start,
//     so result = a - b - borrow_in. This allows instances to be chained.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   request, sampled only in IDLE
//   a, b       in   minuend / subtrahend, captured on accepted start
//   borrow_in  in   (optional) initial borrow, captured on accepted start
//   busy       out  high while in RUN
//   done       out  one-cycle pulse, result valid
//   diff       out  registered (a - b) mod 2^WIDTH
//   borrow_out out  final borrow (a < b unsigned)
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
    input  logic             borrow_in,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sh;
    logic [CW-1:0]    r_cnt;
    logic             r_bin;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic             w_d;
    logic             w_bout;
    logic             w_last;
    logic             w_bin_init;
    logic [WIDTH-1:0] w_sh_next;

`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
    assign w_bin_init = borrow_in;
`else
    assign w_bin_init = 1'b0;
`endif

    // Full-subtract cell on the current LSBs and the registered borrow
    assign w_d    = r_a[0] ^ r_b[0] ^ r_bin;
    assign w_bout = (~(r_a[0] ^ r_b[0]) & r_bin) | (~r_a[0] & r_b[0]);

    // Count is the number of bits already processed, so the value WIDTH-1
    // marks the edge that handles the final bit
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // The difference bit enters at the MSB. After WIDTH shifts, bit i is at
    // position i.
    generate
        if (WIDTH == 1) begin : g_sh1
            assign w_sh_next = w_d;
        end else begin : g_shn
            assign w_sh_next = {w_d, r_sh[WIDTH-1:1]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_sh   <= '0;
            r_cnt  <= '0;
            r_bin  <= 1'b0;
            r_diff <= '0;
            r_bout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_cnt <= '0;
                        r_bin <= w_bin_init;
                    end
                end
                S_RUN: begin
                    r_sh  <= w_sh_next;
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_bin <= w_bout;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_diff <= w_sh_next;
                        r_bout <= w_bout;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy       = (r_state == S_RUN);
        done       = (r_state == S_DONE);
        diff       = r_diff;
        borrow_out = r_bout;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       bin = 1'b0;
    logic       busy, done, bout;
    logic [7:0] diff;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       busy1, done1, bout1;
    logic [0:0] diff1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
        .borrow_in(bin),
`endif
        .busy(busy), .done(done), .diff(diff), .borrow_out(bout)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
        .borrow_in(1'b0),
`endif
        .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bout1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one WIDTH=8 operation and check the busy length, done latency,
    // the single-cycle done pulse and the result
    task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic tbin, input logic [7:0] ed, input logic eb);
        int n;
        int nbusy;
        a = ta; b = tb_; bin = tbin; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = 8'hxx; b = 8'hxx; bin = 1'bx;
        n = 0; nbusy = 0;
        while (!done && n < 40) begin
            if (busy) nbusy++;
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, 8);
        chk({tag, "_busycyc"}, nbusy, 8);
        chk({tag, "_busy_in_done"}, busy, 0);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_bout"}, bout, eb);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    task automatic run1(input string tag, input logic ta, input logic tb_,
                        input logic ed, input logic eb);
        a1 = ta; b1 = tb_; start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        chk({tag, "_busy"}, busy1, 1);
        @(negedge clk);
        chk({tag, "_done"}, done1, 1);
        chk({tag, "_diff"}, diff1, ed);
        chk({tag, "_bout"}, bout1, eb);
        @(negedge clk);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 8'h00);
        chk("rst_bout", bout, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run8("op5A23", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0);
        run8("op1020", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1);
        run8("opFFFF", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);

        // Start re-asserted mid-RUN is ignored
        a = 8'h5A; b = 8'h23; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 8'h01; b = 8'h02;
        for (int i = 0; i < 3; i++) @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !done; i++) @(negedge clk);
        chk("midrun_done", done, 1);
        chk("midrun_diff", diff, 8'h37);
        chk("midrun_bout", bout, 0);
        seen = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("midrun_no_second_done", seen, 0);

        // Reset during RUN clears everything at once and drops the operation
        a = 8'h10; b = 8'h20; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_diff", diff, 8'h37);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_diff", diff, 8'h00);
        chk("arst_bout", bout, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("arst_no_done", seen, 0);
        run8("post_rst", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0);

        // Start held high: a new operation is accepted on the first IDLE edge
        a = 8'h03; b = 8'h01; start = 1'b1;
        for (int i = 0; i < 12 && !done; i++) @(negedge clk);
        chk("held_done", done, 1);
        chk("held_diff", diff, 8'h02);
        @(negedge clk);
        chk("held_idle", busy, 0);
        @(negedge clk);
        chk("held_rerun", busy, 1);
        start = 1'b0;
        for (int i = 0; i < 12 && !done; i++) @(negedge clk);
        chk("held2_done", done, 1);
        @(negedge clk);

        // WIDTH=1 exhaustive
        run1("w1_00", 1'b0, 1'b0, 1'b0, 1'b0);
        run1("w1_01", 1'b0, 1'b1, 1'b1, 1'b1);
        run1("w1_10", 1'b1, 1'b0, 1'b1, 1'b0);
        run1("w1_11", 1'b1, 1'b1, 1'b0, 1'b0);

`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
        run8("bin_0000", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        run8("bin_807F", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor computing a - b, LSB first, one bit per clock.
- Sits directly upstream of the full-subtractor cell. Each cycle it presents one minuend/subtrahend bit plus the registered borrow to the cell equations, then collects the difference bit and the outgoing borrow.
- Trades latency for area in datapaths that need a single subtract cell.
- Start/done handshake toward the controlling sequencer.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  single-cycle pulse; result valid
- diff  output  WIDTH  registered difference (a - b) mod 2^WIDTH
- borrow_out  output  1  final borrow; 1 when a < b (unsigned)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: state=IDLE; busy=0, done=0, diff=0, borrow_out=0; internal shift registers, bit counter and borrow flop=0.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - If start=1 at a clk edge: load a and b into shift registers, clear the counter, set the borrow flop to 0, go to RUN.
  - start=0: stay in IDLE.
- RUN, every edge:
  - Take LSBs a0, b0 and the borrow flop bin.
  - d = a0 ^ b0 ^ bin.
  - bout = (~(a0 ^ b0) & bin) | (~a0 & b0).
  - Shift d into the diff shift register from the MSB side, so that after WIDTH shifts bit i sits at position i.
  - Shift both operand registers right by one; borrow flop <= bout; counter++.
  - On the edge where counter reaches WIDTH-1 (i.e. the WIDTH-th processed bit), go to DONE. Also copy the completed shift result into diff and the final bout into borrow_out.
- DONE: done=1 for exactly one cycle, then IDLE on the next edge.
- Latency: start sampled at edge E0. done is high in the cycle following edge E_WIDTH, i.e. WIDTH cycles after acceptance. Throughput is one operation per WIDTH+2 cycles.
- busy is 1 only in RUN; busy and done are never high together.
- diff and borrow_out change only on the completion edge. They hold their value through DONE, IDLE and the next RUN until the next completion.
- start while in RUN or DONE is ignored; no queuing. a and b are don't-care except at the accepted start edge.
- start held high continuously: a new operation is accepted on the first IDLE edge after DONE.
- WIDTH=1: RUN lasts one cycle; the behaviour is identical to a single full-subtract with bin=0.
- Arithmetic is unsigned modulo 2^WIDTH. Overflow/underflow is reported only through borrow_out.
- Reset mid-RUN or in DONE: immediate return to reset values; the partial result is discarded and no done pulse is issued.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_BORROW_IN_EN.
- Defined:
  - Adds input port borrow_in (1 bit) after b.
  - borrow_in is sampled on the accepted start edge and loaded into the borrow flop instead of 0.
  - Result = (a - b - borrow_in) mod 2^WIDTH; borrow_out set when a < b + borrow_in.
  - Permits chaining instances for wider operands.
- Undefined: no borrow_in port; the initial borrow is constant 0.

Test Plan:
- WIDTH=8, reset then start with a=8'h5A, b=8'h23 -> busy high for 8 cycles; done pulses exactly 8 cycles after the start edge; diff=8'h37, borrow_out=0.
- a=8'h10, b=8'h20 -> diff=8'hF0, borrow_out=1. Then a=8'hFF, b=8'hFF -> diff=8'h00, borrow_out=0.
- Start re-asserted with a=8'h01, b=8'h02 mid-RUN of an 8'h5A-8'h23 operation -> ignored. Result still 8'h37/0; no second done until a fresh start in IDLE.
- Assert rst at cycle 4 of RUN -> busy, done, diff, borrow_out all 0 asynchronously. No done pulse follows; the next start completes normally.
- WIDTH=1, exhaustive a,b in {0,1} -> diff/borrow_out match 0-0=0/0, 0-1=1/1, 1-0=1/0, 1-1=0/0; done one cycle after start.
- With SERIAL_SUBTRACTOR_BORROW_IN_EN, WIDTH=8: a=8'h00, b=8'h00, borrow_in=1 -> diff=8'hFF, borrow_out=1. Then a=8'h80, b=8'h7F, borrow_in=1 -> diff=8'h00, borrow_out=0.
